// File: rtl/fifo_rptr_empty_if.sv
// Read-side bus of the async FIFO: read request, synchronized write pointer,
// and the registered read pointer / status outputs.
interface fifo_rptr_empty_if #(
    parameter int unsigned ADDRSIZE = 4
);
    localparam int unsigned PW = ADDRSIZE + 1;

    logic            rinc;
    logic [PW-1:0]   rq2_wptr;
    logic [ADDRSIZE-1:0] raddr;
    logic [PW-1:0]   rptr;
    logic            rempty;
    logic            raempty;
    logic [PW-1:0]   rlevel;
    logic            runderflow;

    modport master (
        output rinc, rq2_wptr,
        input  raddr, rptr, rempty, raempty, rlevel, runderflow
    );

    modport slave (
        input  rinc, rq2_wptr,
        output raddr, rptr, rempty, raempty, rlevel, runderflow
    );
endinterface

// File: rtl/fifo_rptr_empty.sv
// Read-domain pointer and status generator for the async FIFO: binary/Gray
// read pointer, empty/almost-empty flags, fill level and sticky underflow.
module fifo_rptr_empty #(
    parameter int unsigned ADDRSIZE      = 4,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input logic               rclk,
    input logic               rrst_n,
    fifo_rptr_empty_if.slave  rif
);
    localparam int unsigned PW = ADDRSIZE + 1;

    logic [PW-1:0] rbin;
    logic [PW-1:0] rptr_q;
    logic          rempty_q;
    logic          raempty_q;
    logic [PW-1:0] rlevel_q;
    logic          runderflow_q;

    logic          rd_en;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] wbin_s;
    logic [PW-1:0] level_next;

    // Next read pointer; a read against an empty FIFO is blocked
    always_comb begin
        rd_en      = rif.rinc & ~rempty_q;
        rbin_next  = rbin + PW'(rd_en);
        rgray_next = (rbin_next >> 1) ^ rbin_next;
    end

    // Gray-to-binary of the synchronized write pointer, prefix XOR from the MSB
    always_comb begin
        wbin_s         = '0;
        wbin_s[PW-1]   = rif.rq2_wptr[PW-1];
        for (int i = int'(PW) - 2; i >= 0; i--) begin
            wbin_s[i] = wbin_s[i+1] ^ rif.rq2_wptr[i];
        end
        level_next = wbin_s - rbin_next;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin         <= '0;
            rptr_q       <= '0;
            rempty_q     <= 1'b1;
            raempty_q    <= 1'b1;
            rlevel_q     <= '0;
            runderflow_q <= 1'b0;
        end else begin
            rbin         <= rbin_next;
            rptr_q       <= rgray_next;
            // Gray compare keeps empty exact against a pointer in transit
            rempty_q     <= (rgray_next == rif.rq2_wptr);
            raempty_q    <= (level_next <= PW'(AEMPTY_THRESH));
            rlevel_q     <= level_next;
            runderflow_q <= runderflow_q | (rif.rinc & rempty_q);
        end
    end

    assign rif.raddr      = rbin[ADDRSIZE-1:0];
    assign rif.rptr       = rptr_q;
    assign rif.rempty     = rempty_q;
    assign rif.raempty    = raempty_q;
    assign rif.rlevel     = rlevel_q;
    assign rif.runderflow = runderflow_q;

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Self-checking bench for fifo_rptr_empty: directed scenarios plus random
// read/write traffic against an occupancy-count reference model.
module tb_fifo_rptr_empty;
    localparam int unsigned ADDRSIZE = 4;
    localparam int unsigned THRESH   = 2;
    localparam int PMOD  = 32;
    localparam int DEPTH = 16;

    logic rclk;
    logic rrst_n;
    int   checks;
    int   errors;

    fifo_rptr_empty_if #(.ADDRSIZE(ADDRSIZE)) rif ();

    fifo_rptr_empty #(.ADDRSIZE(ADDRSIZE), .AEMPTY_THRESH(THRESH)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .rif    (rif)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // Reference model: counts of words read and written, modulo pointer range
    int   m_rd;
    int   m_wr;
    int   m_level;
    logic m_empty;
    logic m_under;

    function automatic logic [4:0] to_gray(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [16:0] expected_vec();
        logic [4:0] lv;
        logic [3:0] ad;
        lv = 5'(m_level);
        ad = 4'(m_rd % DEPTH);
        return {to_gray(m_rd), ad, m_empty, (m_level <= int'(THRESH)), lv, m_under};
    endfunction

    function automatic logic [16:0] observed_vec();
        return {rif.rptr, rif.raddr, rif.rempty, rif.raempty, rif.rlevel, rif.runderflow};
    endfunction

    task automatic model_reset();
        m_rd = 0; m_wr = 0; m_level = 0; m_empty = 1'b1; m_under = 1'b0;
    endtask

    // Apply inputs at the falling edge, advance the model at the rising edge,
    // then leave 1 time unit for the outputs to settle before the caller checks.
    task automatic cycle(input logic rd, input int wr);
        @(negedge rclk);
        rif.rinc     = rd;
        m_wr         = wr % PMOD;
        rif.rq2_wptr = to_gray(m_wr);
        @(posedge rclk);
        if (rd && m_empty) m_under = 1'b1;
        if (rd && !m_empty) m_rd = (m_rd + 1) % PMOD;
        m_level = (m_wr - m_rd + PMOD) % PMOD;
        m_empty = (m_level == 0);
        #1;
    endtask

    task automatic do_reset();
        @(negedge rclk);
        rif.rinc = 1'b0;
        rif.rq2_wptr = '0;
        rrst_n = 1'b0;
        model_reset();
        @(negedge rclk);
        rrst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [16:0] o, e;
        do_reset();
        checks++;
        o = observed_vec(); e = expected_vec();
        if (o !== e) begin errors++; $display("FAIL reset_state: got %h expected %h", o, e); end
        // Mid-run reset with rbin=5 and rinc held high
        cycle(1'b0, 8);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8);
        checks++;
        if (rif.raddr !== 4'd5) begin errors++; $display("FAIL reset_setup_raddr: got %0d expected 5", rif.raddr); end
        @(negedge rclk);
        rif.rinc = 1'b1;
        #2 rrst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        o = observed_vec(); e = expected_vec();
        if (o !== e) begin errors++; $display("FAIL reset_async: got %h expected %h", o, e); end
        @(negedge rclk);
        rif.rinc = 1'b0;
        rif.rq2_wptr = '0;
        rrst_n = 1'b1;
    endtask

    task automatic test_fill_drain();
        logic [4:0] exp_ptr[3];
        exp_ptr[0] = 5'b00001; exp_ptr[1] = 5'b00011; exp_ptr[2] = 5'b00010;
        do_reset();
        cycle(1'b0, 3);
        checks++;
        if ({rif.rempty, rif.rlevel, rif.raempty} !== {1'b0, 5'd3, 1'b0}) begin
            errors++;
            $display("FAIL fill_level3: got empty=%b level=%0d aempty=%b expected 0/3/0",
                     rif.rempty, rif.rlevel, rif.raempty);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 3);
            checks++;
            if (rif.rptr !== exp_ptr[i] || rif.raddr !== 4'(i + 1) || rif.raempty !== 1'b1
                || rif.rempty !== (i == 2)) begin
                errors++;
                $display("FAIL drain_%0d: got rptr=%b raddr=%0d aempty=%b empty=%b expected %b/%0d/1/%b",
                         i, rif.rptr, rif.raddr, rif.raempty, rif.rempty, exp_ptr[i], i + 1, i == 2);
            end
        end
    endtask

    task automatic test_underflow();
        for (int i = 0; i < 2; i++) cycle(1'b1, 3);
        checks++;
        if ({rif.rptr, rif.raddr, rif.runderflow} !== {5'b00010, 4'd3, 1'b1}) begin
            errors++;
            $display("FAIL underflow_block: got rptr=%b raddr=%0d uf=%b expected 00010/3/1",
                     rif.rptr, rif.raddr, rif.runderflow);
        end
        cycle(1'b0, 3);
        checks++;
        if (rif.runderflow !== 1'b1) begin
            errors++; $display("FAIL underflow_sticky: got %b expected 1", rif.runderflow);
        end
    endtask

    task automatic test_full();
        do_reset();
        cycle(1'b0, 16);
        checks++;
        if ({rif.rlevel, rif.rempty, rif.raempty} !== {5'd16, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL full_level: got level=%0d empty=%b aempty=%b expected 16/0/0",
                     rif.rlevel, rif.rempty, rif.raempty);
        end
        for (int i = 0; i < 16; i++) cycle(1'b1, 16);
        checks++;
        if ({rif.rempty, rif.raddr, rif.rptr} !== {1'b1, 4'd0, 5'b11000}) begin
            errors++;
            $display("FAIL full_drain: got empty=%b raddr=%0d rptr=%b expected 1/0/11000",
                     rif.rempty, rif.raddr, rif.rptr);
        end
    endtask

    task automatic test_wrap();
        logic [4:0] prev;
        int bad;
        do_reset();
        cycle(1'b0, 1);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            prev = rif.rptr;
            cycle(1'b1, m_wr + 1);
            if (rif.rlevel !== 5'd1 || rif.rempty !== 1'b0 || $countones(rif.rptr ^ prev) != 1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL wrap_steady: got %0d bad cycles expected 0", bad); end
        checks++;
        if (rif.rptr !== 5'b00000) begin
            errors++; $display("FAIL wrap_rptr: got %b expected 00000", rif.rptr);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        cycle(1'b0, 2);
        cycle(1'b1, 3);
        checks++;
        if ({rif.rlevel, rif.rempty} !== {5'd2, 1'b0}) begin
            errors++;
            $display("FAIL simultaneous: got level=%0d empty=%b expected 2/0", rif.rlevel, rif.rempty);
        end
    endtask

    task automatic test_random();
        logic [16:0] o, e;
        logic [4:0] prev;
        int bad, gbad;
        do_reset();
        bad = 0; gbad = 0;
        for (int i = 0; i < 400; i++) begin
            int nw;
            nw = m_wr;
            if ((m_wr - m_rd + PMOD) % PMOD < DEPTH && $urandom_range(0, 2) != 0) nw = m_wr + 1;
            prev = rif.rptr;
            cycle(1'($urandom_range(0, 1)), nw);
            o = observed_vec(); e = expected_vec();
            if (o !== e) begin
                bad++;
                if (bad <= 5) $display("FAIL random_cycle_%0d: got %h expected %h", i, o, e);
            end
            if ($countones(rif.rptr ^ prev) > 1) gbad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL random_total: got %0d bad cycles expected 0", bad); end
        checks++;
        if (gbad != 0) begin errors++; $display("FAIL random_gray: got %0d multi-bit steps expected 0", gbad); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rrst_n = 1'b0;
        rif.rinc = 1'b0;
        rif.rq2_wptr = '0;
        model_reset();
        test_reset();
        test_fill_drain();
        test_underflow();
        test_full();
        test_wrap();
        test_simultaneous();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
